// File: rtl/cordic_vec_sched.sv
// Round-robin front end sharing one CORDIC vectoring core; folds (x,y) into quadrant I and restores the full angle.
// Accept at T, core_start at T+1, out_valid at T+2+K; one job in flight, out_ready low stalls in OUT and blocks new accepts.
module cordic_vec_sched #(
    parameter int                            DATA_WIDTH = 16,
    parameter int                            NUM_REQ    = 4,
    parameter int                            ID_WIDTH   = 2,
    parameter logic signed [DATA_WIDTH-1:0]  ANGLE_PI   = 16'sh6488
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    output logic [NUM_REQ-1:0]              req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_x,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]   req_y,
    output logic                            core_start,
    output logic [DATA_WIDTH-1:0]           core_x,
    output logic [DATA_WIDTH-1:0]           core_y,
    input  logic                            core_done,
    input  logic [DATA_WIDTH-1:0]           core_mag,
    input  logic [DATA_WIDTH-1:0]           core_angle,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [ID_WIDTH-1:0]             out_id,
    output logic [DATA_WIDTH-1:0]           out_mag,
    output logic [DATA_WIDTH-1:0]           out_angle
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_t;

    state_t                  state, state_nxt;
    logic [ID_WIDTH-1:0]     ptr;
    logic [ID_WIDTH-1:0]     grant;
    logic [ID_WIDTH:0]       cand;
    logic                    any_req;
    logic                    sx, sy;
    logic [DATA_WIDTH-1:0]   sel_x, sel_y;
    logic [DATA_WIDTH-1:0]   angle_fix;

    // Most-negative input has no positive twin; clamp it to the largest positive value.
    function automatic logic [DATA_WIDTH-1:0] abs_sat(input logic [DATA_WIDTH-1:0] v);
        logic [DATA_WIDTH-1:0] r;
        if (!v[DATA_WIDTH-1])
            r = v;
        else if (v == {1'b1, {(DATA_WIDTH-1){1'b0}}})
            r = {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            r = -v;
        return r;
    endfunction

    // Scan downward so the candidate closest to ptr (wrapping) wins.
    always_comb begin
        any_req = 1'b0;
        grant   = '0;
        cand    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr} + (ID_WIDTH+1)'(i);
            if (cand >= (ID_WIDTH+1)'(NUM_REQ))
                cand = cand - (ID_WIDTH+1)'(NUM_REQ);
            if (req_valid[cand[ID_WIDTH-1:0]]) begin
                any_req = 1'b1;
                grant   = cand[ID_WIDTH-1:0];
            end
        end
    end

    assign sel_x = req_x[grant*DATA_WIDTH +: DATA_WIDTH];
    assign sel_y = req_y[grant*DATA_WIDTH +: DATA_WIDTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        req_ready  = '0;
        core_start = 1'b0;
        out_valid  = 1'b0;
        case (state)
            IDLE: begin
                if (any_req) begin
                    req_ready[grant] = 1'b1;
                    state_nxt        = ISSUE;
                end
            end
            ISSUE: begin
                core_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (core_done)
                    state_nxt = OUT;
            end
            OUT: begin
                out_valid = 1'b1;
                if (out_ready)
                    state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        case ({sx, sy})
            2'b00:   angle_fix = core_angle;
            2'b10:   angle_fix = ANGLE_PI - core_angle;
            2'b11:   angle_fix = core_angle - ANGLE_PI;
            default: angle_fix = -core_angle;
        endcase
    end

    // Operands are captured at accept so they are already stable when core_start fires.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr       <= '0;
            core_x    <= '0;
            core_y    <= '0;
            sx        <= 1'b0;
            sy        <= 1'b0;
            out_id    <= '0;
            out_mag   <= '0;
            out_angle <= '0;
        end else begin
            if (state == IDLE && any_req) begin
                ptr    <= (grant == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
                core_x <= abs_sat(sel_x);
                core_y <= abs_sat(sel_y);
                sx     <= sel_x[DATA_WIDTH-1];
                sy     <= sel_y[DATA_WIDTH-1];
                out_id <= grant;
            end
            if (state == WAIT && core_done) begin
                out_mag   <= core_mag;
                out_angle <= angle_fix;
            end
        end
    end

endmodule

// File: tb/tb_cordic_vec_sched.sv
// Bench for cordic_vec_sched: latency-K core model plus a quadrant/round-robin reference model.
module tb_cordic_vec_sched;
    localparam int DW = 16;
    localparam int NR = 4;
    localparam int IW = 2;
    localparam int K  = 16;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NR-1:0]     req_valid, req_ready;
    logic [NR*DW-1:0]  req_x, req_y;
    logic              core_start, core_done;
    logic [DW-1:0]     core_x, core_y, core_mag, core_angle;
    logic              out_valid, out_ready;
    logic [IW-1:0]     out_id;
    logic [DW-1:0]     out_mag, out_angle;
    logic [71:0]       all_out;

    int                tests = 0;
    int                fails = 0;
    int                cyc = 0;
    int                start_cnt = 0;
    int                start_cyc = 0;
    int                cnt = 0;
    int                tb_ptr = 0;
    logic              model_done, stray_done;
    logic [DW-1:0]     seen_x, seen_y;
    logic [DW-1:0]     tx [NR];
    logic [DW-1:0]     ty [NR];

    cordic_vec_sched dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
        .core_start(core_start), .core_x(core_x), .core_y(core_y),
        .core_done(core_done), .core_mag(core_mag), .core_angle(core_angle),
        .out_valid(out_valid), .out_ready(out_ready), .out_id(out_id),
        .out_mag(out_mag), .out_angle(out_angle)
    );

    always #5 clk = ~clk;

    assign core_done = model_done | stray_done;
    assign all_out   = {req_ready, core_start, core_x, core_y, out_valid, out_id, out_mag, out_angle};

    // Core model: done pulse lands K cycles after the start cycle.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= 0;
            model_done <= 1'b0;
        end else begin
            model_done <= (cnt == 1);
            if (core_start)
                cnt <= K - 1;
            else if (cnt != 0)
                cnt <= cnt - 1;
        end
    end

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (core_start) begin
            start_cnt <= start_cnt + 1;
            start_cyc <= cyc;
            seen_x    <= core_x;
            seen_y    <= core_y;
        end
    end

    function automatic logic [DW-1:0] ref_abs(input logic [DW-1:0] v);
        int s;
        s = $signed(v);
        if (s < 0) s = -s;
        if (s > 32767) s = 32767;
        return 16'(s);
    endfunction

    function automatic logic [DW-1:0] ref_angle(input logic [DW-1:0] x, input logic [DW-1:0] y,
                                                input logic [DW-1:0] a);
        int xi, yi, ai, r;
        xi = $signed(x);
        yi = $signed(y);
        ai = $signed(a);
        if (xi >= 0 && yi >= 0)      r = ai;
        else if (xi < 0 && yi >= 0)  r = 25736 - ai;
        else if (xi < 0)             r = ai - 25736;
        else                         r = -ai;
        return 16'(r);
    endfunction

    function automatic int ref_grant(input logic [NR-1:0] m, input int p);
        for (int k = 0; k < NR; k++)
            if (m[(p + k) % NR]) return (p + k) % NR;
        return 0;
    endfunction

    function automatic logic [NR-1:0] onehot(input int g);
        logic [NR-1:0] e;
        e    = '0;
        e[g] = 1'b1;
        return e;
    endfunction

    task automatic set_req(input int r, input logic [DW-1:0] x, input logic [DW-1:0] y);
        tx[r] = x;
        ty[r] = y;
        req_x[r*DW +: DW] = x;
        req_y[r*DW +: DW] = y;
    endtask

    task automatic wait_grant(input logic [NR-1:0] mask, output logic [NR-1:0] rdy,
                              output int acc, output bit ok);
        req_valid = mask;
        #1;
        ok = 1'b0; rdy = '0; acc = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (req_ready != '0) begin
                rdy = req_ready; acc = cyc; ok = 1'b1;
            end else begin
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic collect(output bit ok, output int oc, output logic [IW-1:0] id,
                           output logic [DW-1:0] mag, output logic [DW-1:0] ang);
        ok = 1'b0; oc = -1; id = '0; mag = '0; ang = '0;
        for (int i = 0; i < 200 && !ok; i++) begin
            if (out_valid) begin
                ok = 1'b1; oc = cyc; id = out_id; mag = out_mag; ang = out_angle;
            end else begin
                @(posedge clk); #1;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        logic [NR-1:0] rdy; int ac, oc; bit ok, ok2;
        logic [IW-1:0] id; logic [DW-1:0] mag, ang;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL reset_hold: got %h want 0", all_out); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL reset_idle: got %h want 0", all_out); end
        tb_ptr = 0;
        set_req(2, 16'h1234, 16'h0567);
        core_angle = 16'h0100; core_mag = 16'h2000;
        wait_grant(4'b0100, rdy, ac, ok);
        tests++;
        if (!ok || rdy !== 4'b0100) begin fails++; $display("FAIL reset_first_job: ok=%0d rdy=%b want 0100", ok, rdy); end
        @(posedge clk); #1;
        req_valid = '0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        tests++;
        if (all_out !== '0) begin fails++; $display("FAIL reset_async: got %h want 0", all_out); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        tb_ptr = 0;
        set_req(0, 16'h0300, 16'h0400);
        set_req(1, 16'h0100, 16'h0100);
        set_req(3, 16'h0100, 16'h0100);
        wait_grant(4'b1111, rdy, ac, ok);
        tests++;
        if (!ok || rdy !== 4'b0001) begin fails++; $display("FAIL reset_ptr: ok=%0d rdy=%b want 0001", ok, rdy); end
        @(posedge clk); #1;
        req_valid = '0;
        tb_ptr = 1;
        collect(ok2, oc, id, mag, ang);
        tests++;
        if (!ok2 || id !== 2'd0 || mag !== 16'h2000 || ang !== 16'h0100) begin
            fails++; $display("FAIL reset_job_out: ok=%0d id=%0d mag=%h ang=%h want id=0 mag=2000 ang=0100", ok2, id, mag, ang);
        end
    endtask

    task automatic test_quadrants();
        logic [DW-1:0] dx [5] = '{16'hF000, 16'h1000, 16'h8000, 16'h0000, 16'hF000};
        logic [DW-1:0] dy [5] = '{16'h0000, 16'hF000, 16'h8000, 16'h0000, 16'h1000};
        logic [DW-1:0] da [5] = '{16'h0000, 16'h1922, 16'h1922, 16'h0000, 16'h1922};
        logic [DW-1:0] de [5] = '{16'h6488, 16'hE6DE, 16'hB49A, 16'h0000, 16'h4B66};
        logic [NR-1:0] rdy, m; int ac, oc, r, g; bit ok, ok2;
        logic [IW-1:0] id; logic [DW-1:0] mag, ang, x, y, a, mg, ea;
        for (int n = 0; n < 30; n++) begin
            r = $urandom_range(0, NR - 1);
            if (n < 5) begin
                x = dx[n]; y = dy[n]; a = da[n]; ea = de[n];
            end else begin
                x = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                y = ($urandom_range(0, 7) == 0) ? 16'h8000 : 16'($urandom);
                a = 16'($urandom_range(0, 32'h3244));
                ea = ref_angle(x, y, a);
            end
            mg = 16'($urandom);
            set_req(r, x, y);
            core_angle = a; core_mag = mg;
            m = onehot(r);
            g = ref_grant(m, tb_ptr);
            wait_grant(m, rdy, ac, ok);
            tests++;
            if (!ok || rdy !== onehot(g)) begin fails++; $display("FAIL quad_grant[%0d]: rdy=%b want %b", n, rdy, onehot(g)); end
            @(posedge clk); #1;
            req_valid = '0;
            tb_ptr = (g + 1) % NR;
            collect(ok2, oc, id, mag, ang);
            tests++;
            if (seen_x !== ref_abs(x) || seen_y !== ref_abs(y)) begin
                fails++; $display("FAIL quad_fold[%0d]: core_x=%h core_y=%h want %h %h", n, seen_x, seen_y, ref_abs(x), ref_abs(y));
            end
            tests++;
            if (!ok2 || id !== IW'(r) || mag !== mg || ang !== ea) begin
                fails++; $display("FAIL quad_out[%0d]: id=%0d mag=%h ang=%h want id=%0d mag=%h ang=%h", n, id, mag, ang, r, mg, ea);
            end
        end
    endtask

    task automatic test_round_robin();
        logic [NR-1:0] rdy; int ac, oc, g; bit ok, ok2;
        logic [IW-1:0] id; logic [DW-1:0] mag, ang;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        tb_ptr = 0;
        for (int r = 0; r < NR; r++) set_req(r, 16'($urandom), 16'($urandom));
        for (int j = 0; j < 5; j++) begin
            g = ref_grant(4'b1111, tb_ptr);
            wait_grant(4'b1111, rdy, ac, ok);
            tests++;
            if (!ok || rdy !== onehot(g)) begin fails++; $display("FAIL rr_grant[%0d]: rdy=%b want %b", j, rdy, onehot(g)); end
            tb_ptr = (g + 1) % NR;
            @(posedge clk); #1;
            tests++;
            if (req_ready !== '0) begin fails++; $display("FAIL rr_pulse[%0d]: req_ready=%b want 0000", j, req_ready); end
            collect(ok2, oc, id, mag, ang);
            tests++;
            if (!ok2 || id !== IW'(g)) begin fails++; $display("FAIL rr_id[%0d]: id=%0d want %0d", j, id, g); end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        logic [NR-1:0] rdy; int ac, oc, r, g; bit ok, ok2;
        logic [IW-1:0] id; logic [DW-1:0] mag, ang, mg, a;
        r = $urandom_range(0, NR - 1);
        set_req(r, 16'($urandom), 16'($urandom));
        a = 16'($urandom_range(0, 32'h3244)); mg = 16'($urandom);
        core_angle = a; core_mag = mg;
        g = ref_grant(onehot(r), tb_ptr);
        wait_grant(onehot(r), rdy, ac, ok);
        @(posedge clk); #1;
        req_valid = '0;
        tb_ptr = (g + 1) % NR;
        out_ready = 1'b0;
        collect(ok2, oc, id, mag, ang);
        tests++;
        if (!ok || !ok2 || id !== IW'(g) || mag !== mg || ang !== ref_angle(tx[g], ty[g], a)) begin
            fails++; $display("FAIL bp_result: id=%0d mag=%h ang=%h want %0d %h %h", id, mag, ang, g, mg, ref_angle(tx[g], ty[g], a));
        end
        req_valid = 4'b1111;
        for (int c = 0; c < 10; c++) begin
            tests++;
            if (out_valid !== 1'b1 || out_id !== id || out_mag !== mag || out_angle !== ang ||
                req_ready !== '0 || core_start !== 1'b0) begin
                fails++; $display("FAIL bp_hold[%0d]: vld=%b id=%0d mag=%h ang=%h rdy=%b start=%b", c, out_valid, out_id, out_mag, out_angle, req_ready, core_start);
            end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        g = ref_grant(4'b1111, tb_ptr);
        tests++;
        if (out_valid !== 1'b0 || req_ready !== onehot(g)) begin
            fails++; $display("FAIL bp_release: vld=%b rdy=%b want 0 %b", out_valid, req_ready, onehot(g));
        end
        @(posedge clk); #1;
        req_valid = '0;
        tb_ptr = (g + 1) % NR;
        collect(ok2, oc, id, mag, ang);
        tests++;
        if (!ok2 || id !== IW'(g) || ang !== ref_angle(tx[g], ty[g], a)) begin
            fails++; $display("FAIL bp_next: id=%0d ang=%h want %0d %h", id, ang, g, ref_angle(tx[g], ty[g], a));
        end
    endtask

    task automatic test_timing();
        logic [NR-1:0] rdy; int ac, oc, r, g, s0; bit ok, ok2, bad;
        logic [IW-1:0] id; logic [DW-1:0] mag, ang, mg, a, last_mag;
        last_mag = core_mag;
        core_mag = 16'h5555; core_angle = 16'h1111;
        stray_done = 1'b1;
        @(posedge clk); #1;
        stray_done = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 3; c++) begin
            if (out_valid !== 1'b0 || core_start !== 1'b0 || out_mag !== last_mag) bad = 1'b1;
            @(posedge clk); #1;
        end
        tests++;
        if (bad) begin fails++; $display("FAIL stray_done: vld=%b start=%b mag=%h want 0 0 %h", out_valid, core_start, out_mag, last_mag); end
        for (int j = 0; j < 3; j++) begin
            r = $urandom_range(0, NR - 1);
            set_req(r, 16'($urandom), 16'($urandom));
            a = 16'($urandom_range(0, 32'h3244)); mg = 16'($urandom);
            core_angle = a; core_mag = mg;
            g = ref_grant(onehot(r), tb_ptr);
            s0 = start_cnt;
            wait_grant(onehot(r), rdy, ac, ok);
            @(posedge clk); #1;
            req_valid = '0;
            tb_ptr = (g + 1) % NR;
            collect(ok2, oc, id, mag, ang);
            tests++;
            if (!ok || start_cnt - s0 != 1 || start_cyc != ac + 1) begin
                fails++; $display("FAIL t_start[%0d]: starts=%0d at %0d want 1 at %0d", j, start_cnt - s0, start_cyc, ac + 1);
            end
            tests++;
            if (!ok2 || oc != ac + 2 + K) begin
                fails++; $display("FAIL t_out[%0d]: out_valid at %0d want %0d", j, oc, ac + 2 + K);
            end
            tests++;
            if (id !== IW'(g) || mag !== mg || ang !== ref_angle(tx[g], ty[g], a)) begin
                fails++; $display("FAIL t_data[%0d]: id=%0d mag=%h ang=%h want %0d %h %h", j, id, mag, ang, g, mg, ref_angle(tx[g], ty[g], a));
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0; req_x = '0; req_y = '0;
        out_ready = 1'b1; core_mag = '0; core_angle = '0; stray_done = 1'b0;
        for (int r = 0; r < NR; r++) begin tx[r] = '0; ty[r] = '0; end
        test_reset();
        test_quadrants();
        test_round_robin();
        test_backpressure();
        test_timing();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
